// File: rtl/elastic_pipe_reg_t.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg_t
//
// Chain of STAGES elastic (2-entry skid) register stages with a valid/ready
// handshake on both sides. Backpressure costs no throughput, FLUSH
// synchronously drops every held item, and OCCUPANCY counts the items held.
// IN_READY, OUT_VALID and OUT_DATA all come straight from flops. So there is
// no combinational path from OUT_READY to IN_READY, and none from IN_* to
// OUT_*.
//
// Parameters:
//   BIT_WIDTH      payload width
//   DEFAULT_VALUE  value loaded into every data register on reset
//   STAGES         number of elastic stages, 1..8
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   FLUSH      synchronous clear of all valid state (data regs keep value)
//   IN_VALID   upstream item present
//   IN_READY   chain accepts an item this cycle (registered)
//   IN_DATA    upstream payload
//   OUT_VALID  item present at the output (registered)
//   OUT_READY  downstream accepts the item
//   OUT_DATA   output payload (registered)
//   OCCUPANCY  items currently held, 0..2*STAGES (registered)
// -----------------------------------------------------------------------------
module elastic_pipe_reg_t #(
   parameter int                   BIT_WIDTH     = 32,
   parameter logic [BIT_WIDTH-1:0] DEFAULT_VALUE = {BIT_WIDTH{1'b0}},
   parameter int                   STAGES        = 2,
   localparam int                  CNT_WIDTH     = $clog2(2*STAGES+1)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 FLUSH,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [BIT_WIDTH-1:0] IN_DATA,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [BIT_WIDTH-1:0] OUT_DATA,
   output logic [CNT_WIDTH-1:0] OCCUPANCY
);

   // The encoding is chosen so that bit 0 is the main-register valid flag and
   // bit 1 is the skid-register valid flag. Both flags are then plain flop
   // outputs.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b11
   } stage_st_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   stage_st_t            state_q [STAGES];
   stage_st_t            state_d [STAGES];
   logic [BIT_WIDTH-1:0] main_q  [STAGES];
   logic [BIT_WIDTH-1:0] main_d  [STAGES];
   logic [BIT_WIDTH-1:0] skid_q  [STAGES];
   logic [BIT_WIDTH-1:0] skid_d  [STAGES];
   logic [CNT_WIDTH-1:0] occ_q;
   logic [CNT_WIDTH-1:0] occ_d;
   logic                 in_ready_q;
   logic                 in_ready_d;

   logic                 up_valid_s   [STAGES];
   logic [BIT_WIDTH-1:0] up_data_s    [STAGES];
   logic                 down_ready_s [STAGES];
   logic                 acc_s        [STAGES];
   logic                 dep_s        [STAGES];
   logic                 in_fire_s;
   logic                 out_fire_s;

   // Stage k takes its input from stage k-1, or from the IN_* ports for the
   // first stage. Its downstream ready is the next stage's !skid_valid, or
   // OUT_READY for the last stage. Every term here is a flop output or a
   // primary input, so no combinational ready path runs through the chain.
   for (genvar k = 0; k < STAGES; k++) begin : g_link
      if (k == 0) begin : g_head
         assign up_valid_s[k] = IN_VALID;
         assign up_data_s[k]  = IN_DATA;
      end else begin : g_mid
         assign up_valid_s[k] = state_q[k-1][0];
         assign up_data_s[k]  = main_q[k-1];
      end
      if (k == STAGES-1) begin : g_tail
         assign down_ready_s[k] = OUT_READY;
      end else begin : g_inner
         assign down_ready_s[k] = ~state_q[k+1][1];
      end
      assign acc_s[k] = up_valid_s[k] & ~state_q[k][1];
      assign dep_s[k] = state_q[k][0] & down_ready_s[k];
   end

   assign in_fire_s  = acc_s[0];
   assign out_fire_s = dep_s[STAGES-1];

   // Per-stage next state and data-register load enables; FLUSH overrides all
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         state_d[k] = state_q[k];
         main_d[k]  = main_q[k];
         skid_d[k]  = skid_q[k];
         if (FLUSH) begin
            // Valid state drops; data registers deliberately keep their value
            state_d[k] = ST_EMPTY;
         end else begin
            case (state_q[k])
               ST_EMPTY: begin
                  if (acc_s[k]) begin
                     state_d[k] = ST_ONE;
                     main_d[k]  = up_data_s[k];
                  end else begin
                     state_d[k] = ST_EMPTY;
                  end
               end
               ST_ONE: begin
                  if (acc_s[k] && dep_s[k]) begin
                     state_d[k] = ST_ONE;
                     main_d[k]  = up_data_s[k];
                  end else if (acc_s[k]) begin
                     state_d[k] = ST_TWO;
                     skid_d[k]  = up_data_s[k];
                  end else if (dep_s[k]) begin
                     state_d[k] = ST_EMPTY;
                  end else begin
                     state_d[k] = ST_ONE;
                  end
               end
               ST_TWO: begin
                  // in_ready is low here, so only a departure can happen
                  if (dep_s[k]) begin
                     state_d[k] = ST_ONE;
                     main_d[k]  = skid_q[k];
                  end else begin
                     state_d[k] = ST_TWO;
                  end
               end
               default: begin
                  state_d[k] = ST_EMPTY;
               end
            endcase
         end
      end
   end

   // Occupancy update and registered copy of the head stage's in_ready
   always_comb begin
      occ_d      = occ_q;
      in_ready_d = (state_d[0] != ST_TWO);
      if (FLUSH) begin
         occ_d = CNT_ZERO;
      end else if (in_fire_s && !out_fire_s) begin
         occ_d = occ_q + CNT_ONE;
      end else if (!in_fire_s && out_fire_s) begin
         occ_d = occ_q - CNT_ONE;
      end else begin
         occ_d = occ_q;
      end
   end

   // State, data and counter registers with asynchronous reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < STAGES; k++) begin
            state_q[k] <= ST_EMPTY;
            main_q[k]  <= DEFAULT_VALUE;
            skid_q[k]  <= DEFAULT_VALUE;
         end
         occ_q      <= CNT_ZERO;
         in_ready_q <= 1'b1;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            state_q[k] <= state_d[k];
            main_q[k]  <= main_d[k];
            skid_q[k]  <= skid_d[k];
         end
         occ_q      <= occ_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = state_q[STAGES-1][0];
   assign OUT_DATA  = main_q[STAGES-1];
   assign OCCUPANCY = occ_q;

endmodule

// File: tb/tb_elastic_pipe_reg_t.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_reg_t
//
// Four chains (STAGES = 1, 2, 3, 8) share the same stimulus. A negedge
// scoreboard keeps an item queue per chain. It checks FIFO order, occupancy
// and output stability under stall for every chain on every cycle. Timing
// checks with exact cycle counts target the STAGES = 2 chain (index 1).
// -----------------------------------------------------------------------------
module tb_elastic_pipe_reg_t;

   localparam int NDUT = 4;
   localparam int D2   = 1;   // index of the STAGES = 2 chain
   localparam logic [31:0] DEFV = 32'hDEADBEEF;

   function automatic int st_of(input int d);
      case (d)
         0:       return 1;
         1:       return 2;
         2:       return 3;
         default: return 8;
      endcase
   endfunction

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        in_ready_w  [NDUT];
   logic        out_valid_w [NDUT];
   logic [31:0] out_data_w  [NDUT];
   logic [4:0]  occ_w       [NDUT];

   int n_checks;
   int n_fail;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int S = st_of(g);
      logic [$clog2(2*S+1)-1:0] occ_s;
      elastic_pipe_reg_t #(
         .BIT_WIDTH    (32),
         .DEFAULT_VALUE(DEFV),
         .STAGES       (S)
      ) u_dut (
         .CLK      (clk),
         .RST      (rst),
         .FLUSH    (flush),
         .IN_VALID (in_valid),
         .IN_READY (in_ready_w[g]),
         .IN_DATA  (in_data),
         .OUT_VALID(out_valid_w[g]),
         .OUT_READY(out_ready),
         .OUT_DATA (out_data_w[g]),
         .OCCUPANCY(occ_s)
      );
      assign occ_w[g] = 5'(occ_s);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- scoreboard
   logic [31:0] sb_q [NDUT][$];
   logic        stalled_prev [NDUT];
   logic [31:0] held_data    [NDUT];

   // Reference model: one FIFO of accepted items per chain, updated once per cycle
   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (rst) begin
            sb_q[d].delete();
            stalled_prev[d] = 1'b0;
         end else begin
            check_eq($sformatf("occ_vs_model_s%0d", st_of(d)), 32'(occ_w[d]), 32'(sb_q[d].size()));
            if (stalled_prev[d]) begin
               check_eq($sformatf("stall_valid_s%0d", st_of(d)), 32'(out_valid_w[d]), 32'd1);
               check_eq($sformatf("stall_data_s%0d", st_of(d)), out_data_w[d], held_data[d]);
            end
            if (sb_q[d].size() == 2*st_of(d))
               check_eq($sformatf("full_no_ready_s%0d", st_of(d)), 32'(in_ready_w[d]), 32'd0);
            if (out_valid_w[d] && out_ready) begin
               if (sb_q[d].size() > 0)
                  check_eq($sformatf("fifo_order_s%0d", st_of(d)), out_data_w[d], sb_q[d].pop_front());
               else
                  check_eq($sformatf("pop_from_empty_s%0d", st_of(d)), 32'(sb_q[d].size()), 32'd1);
            end
            if (in_valid && in_ready_w[d] && !flush)
               sb_q[d].push_back(in_data);
            if (flush)
               sb_q[d].delete();
            stalled_prev[d] = out_valid_w[d] && !out_ready && !flush;
            held_data[d]    = out_data_w[d];
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         stalled_prev[d] = 1'b0;
         held_data[d]    = 32'h0;
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_eq("rst_out_valid", 32'(out_valid_w[D2]), 32'd0);
      check_eq("rst_out_data",  out_data_w[D2],        DEFV);
      check_eq("rst_in_ready",  32'(in_ready_w[D2]),  32'd1);
      check_eq("rst_occ",       32'(occ_w[D2]),       32'd0);

      // Streaming: 0x10..0x17 back to back with OUT_READY held high
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 8);
         in_data  = 32'h10 + 32'(i);
         step();
         check_eq("stream_in_ready", 32'(in_ready_w[D2]), 32'd1);
         check_eq("stream_out_valid", 32'(out_valid_w[D2]), 32'((i >= 1) && (i <= 8)));
         if ((i >= 1) && (i <= 8))
            check_eq("stream_out_data", out_data_w[D2], 32'h10 + 32'(i - 1));
         check_eq("stream_occ", 32'(occ_w[D2]),
                  32'(((i + 1 < 8) ? i + 1 : 8) - ((i > 1) ? i - 1 : 0)));
      end

      // Fill under stall: six pushes offered, capacity is four
      do_reset();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hA0 + 32'(i);
         step();
         check_eq("fill_in_ready", 32'(in_ready_w[D2]), 32'(i < 3));
         check_eq("fill_occ",      32'(occ_w[D2]),      32'((i + 1 < 4) ? i + 1 : 4));
         check_eq("fill_out_valid", 32'(out_valid_w[D2]), 32'(i >= 1));
         if (i >= 1)
            check_eq("fill_out_data", out_data_w[D2], 32'hA0);
      end
      // Drain: the release of backpressure ripples back one stage per cycle
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("drain_out_valid", 32'(out_valid_w[D2]), 32'(k < 3));
         if (k < 3)
            check_eq("drain_out_data", out_data_w[D2], 32'hA1 + 32'(k));
         check_eq("drain_occ",      32'(occ_w[D2]),      32'(3 - k));
         check_eq("drain_in_ready", 32'(in_ready_w[D2]), 32'(k >= 1));
      end

      // Flush with three items held and 0x55 offered in the flush cycle
      do_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h1 + 32'(i);
         step();
      end
      check_eq("preflush_occ", 32'(occ_w[D2]), 32'd3);
      in_data = 32'h55;
      flush   = 1'b1;
      step();
      check_eq("flush_out_valid", 32'(out_valid_w[D2]), 32'd0);
      check_eq("flush_occ",       32'(occ_w[D2]),       32'd0);
      flush     = 1'b0;
      in_data   = 32'h66;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("post_flush_latency", 32'(out_valid_w[D2]), 32'd0);
      step();
      check_eq("post_flush_valid", 32'(out_valid_w[D2]), 32'd1);
      check_eq("post_flush_data",  out_data_w[D2],        32'h66);
      step();
      check_eq("post_flush_empty", 32'(occ_w[D2]), 32'd0);

      // Asynchronous reset while every chain is full
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 32'hC0 + 32'(i);
         step();
      end
      check_eq("full_in_ready", 32'(in_ready_w[D2]), 32'd0);
      check_eq("full_occ",      32'(occ_w[D2]),      32'd4);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check_eq($sformatf("arst_out_valid_s%0d", st_of(d)), 32'(out_valid_w[d]), 32'd0);
         check_eq($sformatf("arst_out_data_s%0d", st_of(d)),  out_data_w[d],        DEFV);
         check_eq($sformatf("arst_in_ready_s%0d", st_of(d)),  32'(in_ready_w[d]),  32'd1);
         check_eq($sformatf("arst_occ_s%0d", st_of(d)),       32'(occ_w[d]),       32'd0);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      in_data = 32'h77;
      step();
      in_valid = 1'b0;
      for (int d = 0; d < NDUT; d++)
         check_eq($sformatf("first_accept_s%0d", st_of(d)), 32'(occ_w[d]), 32'd1);

      // Simultaneous in/out fire with three items held
      do_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hB0 + 32'(i);
         step();
      end
      check_eq("sim_pre_occ",      32'(occ_w[D2]),      32'd3);
      check_eq("sim_pre_in_ready", 32'(in_ready_w[D2]), 32'd1);
      in_data   = 32'hB3;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("sim_occ",       32'(occ_w[D2]),       32'd3);
      check_eq("sim_out_valid", 32'(out_valid_w[D2]), 32'd1);
      check_eq("sim_out_data",  out_data_w[D2],        32'hB1);
      repeat (6) step();
      check_eq("sim_drained", 32'(occ_w[D2]), 32'd0);

      // Random valid/ready with occasional flush, three bias phases
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int pv;
         int pr;
         case (c / 1000)
            0:       begin pv = 50; pr = 50; end
            1:       begin pv = 85; pr = 30; end
            default: begin pv = 30; pr = 85; end
         endcase
         in_valid  = ($urandom_range(99) < 32'(pv));
         out_ready = ($urandom_range(99) < 32'(pr));
         in_data   = $urandom();
         flush     = ($urandom_range(199) == 0);
         step();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (40) step();
      for (int d = 0; d < NDUT; d++) begin
         check_eq($sformatf("final_drain_occ_s%0d", st_of(d)),   32'(occ_w[d]),       32'd0);
         check_eq($sformatf("final_drain_valid_s%0d", st_of(d)), 32'(out_valid_w[d]), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
